// File: rtl/mips_dlx.sv
// Single-cycle 32-bit MIPS/DLX core with an internal program ROM and data RAM.
// Executes add/sub/and/or/slt, addi, lw, sw, beq and j; anything else is a NOP.
module mips_dlx #(
    parameter int unsigned IMEM_WORDS = 64,
    parameter int unsigned DMEM_WORDS = 64
) (
    input  logic clock,
    input  logic reset,
    output logic zero
);

    localparam int unsigned ImemAw = $clog2(IMEM_WORDS);
    localparam int unsigned DmemAw = $clog2(DMEM_WORDS);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    typedef enum logic [2:0] {AluAdd, AluSub, AluAnd, AluOr, AluSlt} alu_op_e;

    logic [31:0] pc_q, pc_d;
    logic [31:0] rf_q [32];
    logic [31:0] dmem_q [DMEM_WORDS];
    logic        zero_q, zero_d;

    logic [31:0] instr;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd;
    logic [31:0] imm_sext;
    logic [31:0] rs_val, rt_val;
    logic [31:0] pc_plus4, pc_next;
    logic [31:0] alu_b, alu_result;
    logic [31:0] mem_rdata;
    alu_op_e     alu_op;
    logic        valid, is_jump, is_branch;
    logic        reg_we, mem_we, wb_from_mem, use_imm;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  unused_shamt;

    // Program ROM; unprogrammed words read as 0 (sll $0, a NOP).
    always_comb begin
        instr = 32'h0000_0000;
        unique case (pc_q[ImemAw+1:2])
            ImemAw'(0): instr = 32'h2001_0005;  // addi $1,$0,5
            ImemAw'(1): instr = 32'h2002_0005;  // addi $2,$0,5
            ImemAw'(2): instr = 32'h0022_1822;  // sub  $3,$1,$2
            ImemAw'(3): instr = 32'h0022_2020;  // add  $4,$1,$2
            ImemAw'(4): instr = 32'hAC04_0004;  // sw   $4,4($0)
            ImemAw'(5): instr = 32'h8C05_0004;  // lw   $5,4($0)
            ImemAw'(6): instr = 32'h10A4_0001;  // beq  $5,$4,+1
            ImemAw'(7): instr = 32'h2006_0001;  // addi $6,$0,1
            ImemAw'(8): instr = 32'h0800_0008;  // j    8
            default:    instr = 32'h0000_0000;
        endcase
    end

    assign opcode       = instr[31:26];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign unused_shamt = instr[10:6];
    assign funct        = instr[5:0];
    assign imm_sext     = {{16{instr[15]}}, instr[15:0]};
    assign rs_val       = rf_q[rs];
    assign rt_val       = rf_q[rt];
    assign pc_plus4     = pc_q + 32'd4;

    // Decode: NOP by default so unsupported encodings change nothing but PC.
    always_comb begin
        valid       = 1'b0;
        is_jump     = 1'b0;
        is_branch   = 1'b0;
        reg_we      = 1'b0;
        mem_we      = 1'b0;
        wb_from_mem = 1'b0;
        use_imm     = 1'b0;
        wr_addr     = rd;
        alu_op      = AluAdd;
        unique case (opcode)
            OpRtype: begin
                valid = 1'b1;
                unique case (funct)
                    FnAdd:   alu_op = AluAdd;
                    FnSub:   alu_op = AluSub;
                    FnAnd:   alu_op = AluAnd;
                    FnOr:    alu_op = AluOr;
                    FnSlt:   alu_op = AluSlt;
                    default: valid  = 1'b0;
                endcase
                reg_we = valid;
            end
            OpAddi: begin
                valid = 1'b1; reg_we = 1'b1; use_imm = 1'b1; wr_addr = rt;
            end
            OpLw: begin
                valid = 1'b1; reg_we = 1'b1; use_imm = 1'b1; wr_addr = rt; wb_from_mem = 1'b1;
            end
            OpSw: begin
                valid = 1'b1; mem_we = 1'b1; use_imm = 1'b1;
            end
            OpBeq: begin
                valid = 1'b1; is_branch = 1'b1; alu_op = AluSub;
            end
            OpJ:     is_jump = 1'b1;
            default: valid = 1'b0;
        endcase
    end

    // ALU, wrap-around arithmetic with no overflow detection.
    always_comb begin
        alu_b = use_imm ? imm_sext : rt_val;
        unique case (alu_op)
            AluAdd:  alu_result = rs_val + alu_b;
            AluSub:  alu_result = rs_val - alu_b;
            AluAnd:  alu_result = rs_val & alu_b;
            AluOr:   alu_result = rs_val | alu_b;
            AluSlt:  alu_result = {31'd0, $signed(rs_val) < $signed(alu_b)};
            default: alu_result = 32'h0;
        endcase
    end

    assign mem_rdata = dmem_q[alu_result[DmemAw+1:2]];
    assign wr_data   = wb_from_mem ? mem_rdata : alu_result;

    // Next PC selection and zero-flag update.
    always_comb begin
        pc_next = pc_plus4;
        zero_d  = zero_q;
        if (is_jump) begin
            pc_next = {pc_plus4[31:28], instr[25:0], 2'b00};
        end else if (valid) begin
            zero_d = (alu_result == 32'h0);
            if (is_branch && zero_d) begin
                pc_next = pc_plus4 + {imm_sext[29:0], 2'b00};
            end
        end
        // Wrap within the ROM address space.
        pc_d = {{(30-ImemAw){1'b0}}, pc_next[ImemAw+1:0]};
    end

    // PC, register file and zero flag; asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q   <= 32'h0;
            zero_q <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else begin
            pc_q   <= pc_d;
            zero_q <= zero_d;
            if (reg_we && (wr_addr != 5'd0)) begin
                rf_q[wr_addr] <= wr_data;
            end
        end
    end

    // Data RAM write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            dmem_q[alu_result[DmemAw+1:2]] <= rt_val;
        end
    end

    assign zero = zero_q;

endmodule

// File: tb/tb_mips_dlx.sv
// Directed bench for mips_dlx: runs the built-in program, checks architectural state.
module tb_mips_dlx;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic zero;

    int n_tests = 0;
    int n_fail  = 0;

    mips_dlx #(.IMEM_WORDS(64), .DMEM_WORDS(64)) dut (
        .clock(clock),
        .reset(reset),
        .zero (zero)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Edges 1-3 after a reset release.
    task automatic run_first_three(input string pfx);
        step();
        check({pfx, " e1 zero"}, 32'(zero), 32'd0);
        check({pfx, " e1 $1"}, dut.rf_q[1], 32'd5);
        step();
        check({pfx, " e2 zero"}, 32'(zero), 32'd0);
        check({pfx, " e2 $2"}, dut.rf_q[2], 32'd5);
        step();
        check({pfx, " e3 zero"}, 32'(zero), 32'd1);
        check({pfx, " e3 $3"}, dut.rf_q[3], 32'd0);
        check({pfx, " e3 pc"}, dut.pc_q, 32'h0C);
    endtask

    initial begin
        // Reset held for 130 ns with the clock running.
        for (int t = 0; t < 13; t++) begin
            #10;
            check("rst zero", 32'(zero), 32'd0);
        end
        check("rst pc", dut.pc_q, 32'h0);
        check("rst $1", dut.rf_q[1], 32'h0);
        check("rst $4", dut.rf_q[4], 32'h0);
        @(negedge clock);
        reset = 1'b0;

        run_first_three("run1");
        step();
        check("run1 e4 zero", 32'(zero), 32'd0);
        check("run1 e4 $4", dut.rf_q[4], 32'd10);
        check("run1 e4 pc", dut.pc_q, 32'h10);

        // Asynchronous reset between edges 4 and 5.
        #2;
        reset = 1'b1;
        #1;
        check("async zero", 32'(zero), 32'd0);
        check("async pc", dut.pc_q, 32'h0);
        check("async $4", dut.rf_q[4], 32'h0);
        step();
        check("rst hold pc", dut.pc_q, 32'h0);
        check("rst hold $1", dut.rf_q[1], 32'h0);
        @(negedge clock);
        reset = 1'b0;

        run_first_three("run2");
        step();
        check("e4 zero", 32'(zero), 32'd0);
        check("e4 $4", dut.rf_q[4], 32'd10);
        step();
        check("e5 zero", 32'(zero), 32'd0);
        check("e5 ram1", dut.dmem_q[1], 32'd10);
        step();
        check("e6 zero", 32'(zero), 32'd0);
        check("e6 $5", dut.rf_q[5], 32'd10);
        step();
        check("e7 zero", 32'(zero), 32'd1);
        check("e7 pc", dut.pc_q, 32'h20);
        for (int i = 0; i < 5; i++) begin
            step();
            check("loop pc", dut.pc_q, 32'h20);
            check("loop zero", 32'(zero), 32'd1);
        end
        check("skip $6", dut.rf_q[6], 32'h0);
        check("final $0", dut.rf_q[0], 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_dlx.md
MIPS_DLX -- requirements
Module: mips_dlx

Interface
REQ-001 Parameter IMEM_WORDS, default 64, is the instruction ROM depth in 32-bit words, word-addressed by PC[7:2].
REQ-002 Parameter DMEM_WORDS, default 64, is the data RAM depth in 32-bit words, word-addressed by ALU result[7:2].
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port zero, output, 1 bit: registered ALU-zero flag of the most recently executed non-jump instruction.

Function
REQ-006 The core SHALL be a single-cycle 32-bit MIPS/DLX processor that executes one instruction per rising clock edge while reset is low.
REQ-007 State: 32-bit PC; 32x32 register file with $0 hardwired to 0; internal instruction ROM; internal data RAM; zero register.
REQ-008 Supported R-type instructions (opcode 0x00), selected by funct: add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed); result written to rd.
REQ-009 Supported I-type instructions: addi 0x08 (sign-extended immediate, result to rt); lw 0x23; sw 0x2B; beq 0x04.
REQ-010 Supported J-type instruction: j 0x02, target = {PC+4[31:28], imm26, 2'b00}.
REQ-011 Unsupported opcodes or funct codes SHALL execute as NOP: no register or memory write, zero unchanged, PC+4.
REQ-012 Arithmetic SHALL be 32-bit two's-complement wrap-around; overflow is ignored, with no trap.
REQ-013 lw/sw address = rs + sign-extended imm16; RAM read is combinational; RAM write occurs on the clock edge.
REQ-014 beq computes rs - rt; if the result is 0, next PC = PC+4 + (sign-extended imm16 << 2), else PC+4.
REQ-015 Writes to $0 SHALL be discarded; a read of the register written in the same cycle returns the old value.
REQ-016 On every executed non-jump supported instruction, zero <= (ALU result == 32'h0); lw/sw use the address sum; j leaves zero unchanged.
REQ-017 PC SHALL wrap modulo the ROM size; a fetch beyond the programmed ROM contents returns 0x00000000, which executes as a NOP (sll $0).
REQ-018 ROM contents SHALL be fixed at elaboration as follows (word address: instruction):
  0: addi $1,$0,5
  1: addi $2,$0,5
  2: sub $3,$1,$2
  3: add $4,$1,$2
  4: sw $4,4($0)
  5: lw $5,4($0)
  6: beq $5,$4,+1
  7: addi $6,$0,1
  8: j 8

Reset
REQ-019 While reset is high, regardless of clock: PC = 0, all registers = 0, zero = 0; no memory writes occur.
REQ-020 Reset assertion mid-program SHALL take effect immediately (asynchronous); the data RAM is not cleared.
REQ-021 After reset deasserts, the first rising edge executes the instruction at address 0.

Verification
REQ-022 Reset held high for 130 ns with a 10 ns clock -> zero = 0 at all times, PC = 0, no register changes.
REQ-023 Release reset and apply rising edges 1-3 -> zero = 0, 0, 1; $1 = 5, $2 = 5, $3 = 0.
REQ-024 Apply edges 4-6 -> zero = 0, 0, 0; $4 = 10; RAM word 1 = 10; $5 = 10.
REQ-025 Apply edge 7 (beq taken) -> zero = 1, PC = 0x20; then after 5 more edges -> PC stays 0x20, zero stays 1, $6 = 0 (instruction at address 7 skipped).
REQ-026 Assert reset asynchronously between edges 4 and 5 -> zero = 0 and PC = 0 immediately, without waiting for a clock edge; after release, re-execution reproduces the REQ-023 sequence.
